// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between N_CORES cores and sequences their run/stall/finish status.
// Optional: define ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority instead of round-robin.
module data_mem_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [N_CORES-1:0]          req,
    input  logic [N_CORES-1:0]          we_in,
    input  logic [N_CORES*ADDR_W-1:0]   addr_in,
    input  logic [N_CORES*DATA_W-1:0]   wdata_in,
    input  logic [N_CORES-1:0]          end_process,
    output logic [N_CORES-1:0]          grant,
    output logic [N_CORES-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata_out,
    output logic [2*N_CORES-1:0]        core_status,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic                        done
);

    // state | meaning
    // IDLE  | cores held (00), no grants, wait for start
    // RUN   | arbitrate memory, collect end_process into finished mask
    // DRAIN | one cycle so the last read's rvalid completes
    // DONE  | all cores finished (11), done high, start relaunches
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [N_CORES-1:0] finished;
    logic [N_CORES-1:0] eligible;
    logic [PTR_W-1:0]   gidx;
    logic               gvalid;

    // Reset gates arbitration so a pending write never reaches memory in the reset cycle.
    always_comb begin
        int idx;
        idx      = 0;
        eligible = (state == RUN && !reset) ? (req & ~finished) : '0;
        gidx     = '0;
        gvalid   = 1'b0;
        grant    = '0;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < N_CORES; k++) begin
            if (!gvalid && eligible[k]) begin
                gvalid = 1'b1;
                gidx   = PTR_W'(k);
            end
        end
`else
        for (int k = 0; k < N_CORES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_CORES)
                idx = idx - N_CORES;
            if (!gvalid && eligible[idx[PTR_W-1:0]]) begin
                gvalid = 1'b1;
                gidx   = idx[PTR_W-1:0];
            end
        end
`endif
        if (gvalid)
            grant[gidx] = 1'b1;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (grant[i]) begin
                mem_we    = we_in[i];
                mem_addr  = addr_in[i*ADDR_W +: ADDR_W];
                mem_wdata = wdata_in[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        core_status = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (reset || state == IDLE)
                core_status[2*i +: 2] = 2'b00;
            else if (state == DONE || finished[i])
                core_status[2*i +: 2] = 2'b11;
            else if (req[i] && !grant[i])
                core_status[2*i +: 2] = 2'b10;
            else
                core_status[2*i +: 2] = 2'b01;
        end
    end

    assign busy      = !reset && (state == RUN || state == DRAIN);
    assign done      = !reset && (state == DONE);
    assign rdata_out = (|rvalid) ? mem_rdata : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            finished <= '0;
            rvalid   <= '0;
        end else begin
            rvalid <= grant & ~we_in;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        finished <= '0;
                    end
                end
                RUN: begin
                    finished <= finished | end_process;
`ifndef ARB_FIXED_PRIORITY_EN
                    if (gvalid)
                        ptr <= (gidx == PTR_W'(N_CORES - 1)) ? '0 : gidx + 1'b1;
`endif
                    if (&finished)
                        state <= DRAIN;
                end
                DRAIN: state <= DONE;
                DONE: begin
                    if (start) begin
                        state    <= RUN;
                        finished <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural single-port memory model.
module tb_data_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  req;
    logic [3:0]  we_in;
    logic [31:0] addr_in;
    logic [63:0] wdata_in;
    logic [3:0]  end_process;
    logic [3:0]  grant;
    logic [3:0]  rvalid;
    logic [15:0] rdata_out;
    logic [7:0]  core_status;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:255];
    int n_chk  = 0;
    int n_pass = 0;

    data_mem_arbiter #(.N_CORES(4), .ADDR_W(8), .DATA_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .req(req), .we_in(we_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .end_process(end_process),
        .grant(grant), .rvalid(rvalid), .rdata_out(rdata_out), .core_status(core_status),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h5000 + 16'(i);
        mem_rdata = '0;
    end

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    logic [3:0] eg;
    logic [3:0] fin;
    logic [7:0] es;

    initial begin
        reset = 1; start = 0; req = 0; we_in = 0; addr_in = 0; wdata_in = 0; end_process = 0;
        cyc(); cyc();
        reset = 0; #1;
        check("rst_grant", grant, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata_out, 0);
        check("rst_status", core_status, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        start = 1; cyc(); start = 0; #1;
        check("run_status", core_status, 8'h55);
        check("run_busy", busy, 1);
        check("run_grant", grant, 0);
        check("run_mem_we", mem_we, 0);

        // two simultaneous reads, ptr at 0
        req = 4'b0101; addr_in[7:0] = 8'h10; addr_in[23:16] = 8'h20; #1;
        check("rd_grant0", grant, 4'b0001);
        check("rd_status2", core_status[5:4], 2'b10);
        check("rd_addr0", mem_addr, 8'h10);
        cyc(); req = 4'b0100; #1;
        check("rd_grant2", grant, 4'b0100);
        check("rd_rvalid0", rvalid, 4'b0001);
        check("rd_rdata0", rdata_out, 16'h5010);
        check("rd_addr2", mem_addr, 8'h20);
        cyc(); req = 0; #1;
        check("rd_rvalid2", rvalid, 4'b0100);
        check("rd_rdata2", rdata_out, 16'h5020);

        // core 3 write brings ptr back to 0
        req = 4'b1000; we_in = 4'b1000; addr_in[31:24] = 8'h80; wdata_in[63:48] = 16'h1234; #1;
        check("wr3_grant", grant, 4'b1000);
        check("wr3_we", mem_we, 1);
        cyc(); req = 0; we_in = 0; #1;
        check("wr3_no_rvalid", rvalid, 0);
        check("wr3_mem", mem[8'h80], 16'h1234);

        // all cores hold writes: grants rotate 0,1,2,3,...
        req = 4'hF; we_in = 4'hF;
        for (int i = 0; i < 4; i++) begin
            addr_in[i*8 +: 8]   = 8'h40 + 8'(i);
            wdata_in[i*16 +: 16] = 16'hA000 + 16'(i);
        end
        for (int k = 0; k < 8; k++) begin
            #1;
            eg = 4'b0001 << (k % 4);
            es = '0;
            for (int i = 0; i < 4; i++) es[2*i +: 2] = eg[i] ? 2'b01 : 2'b10;
            check($sformatf("rot_grant%0d", k), grant, eg);
            check($sformatf("rot_wdata%0d", k), mem_wdata, 16'hA000 + 16'(k % 4));
            check($sformatf("rot_status%0d", k), core_status, es);
            cyc();
        end
        req = 0; we_in = 0; #1;
        for (int i = 0; i < 4; i++)
            check($sformatf("rot_mem%0d", i), mem[8'h40 + i], 16'hA000 + 16'(i));

        // staggered end_process; core 0 requests in its finishing cycle; start in RUN ignored
        addr_in[7:0] = 8'h10;
        for (int c = 0; c <= 16; c++) begin
            end_process = {c >= 12, c >= 9, c >= 7, c >= 5};
            req   = (c == 5 || c == 6) ? 4'b0001 : 4'b0000;
            start = (c == 8);
            #1;
            fin = {c > 12, c > 9, c > 7, c > 5};
            eg  = (c == 5) ? 4'b0001 : 4'b0000;
            es  = '0;
            for (int i = 0; i < 4; i++) es[2*i +: 2] = fin[i] ? 2'b11 : 2'b01;
            check($sformatf("ep_grant%0d", c), grant, eg);
            check($sformatf("ep_status%0d", c), core_status, es);
            check($sformatf("ep_busy%0d", c), busy, c <= 14);
            check($sformatf("ep_done%0d", c), done, c >= 15);
            if (c == 6) begin
                check("ep_rvalid", rvalid, 4'b0001);
                check("ep_rdata", rdata_out, 16'h5010);
            end
            cyc();
        end
        start = 0; end_process = 0; req = 0;

        // restart from DONE, then reset during a granted write
        start = 1; cyc(); start = 0; #1;
        check("restart_status", core_status, 8'h55);
        req = 4'b0010; we_in = 4'b0010; addr_in[15:8] = 8'h30; wdata_in[31:16] = 16'hBEEF; #1;
        check("abort_pre_grant", grant, 4'b0010);
        check("abort_pre_we", mem_we, 1);
        reset = 1; #1;
        check("abort_we", mem_we, 0);
        cyc(); reset = 0; #1;
        check("abort_status", core_status, 0);
        check("abort_busy", busy, 0);
        check("abort_grant", grant, 0);
        check("abort_mem", mem[8'h30], 16'h5030);
        req = 0; we_in = 0;

        // cores 1 and 3 hold reads
        start = 1; cyc(); start = 0;
        req = 4'b1010; addr_in[15:8] = 8'h01; addr_in[31:24] = 8'h03;
        for (int k = 0; k < 4; k++) begin
            #1;
`ifdef ARB_FIXED_PRIORITY_EN
            eg = 4'b0010;
`else
            eg = (k % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
            check($sformatf("arb_grant%0d", k), grant, eg);
            check($sformatf("arb_status3_%0d", k), core_status[7:6], eg[3] ? 2'b01 : 2'b10);
            cyc();
        end
        req = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
